mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Shares one unified single-port memory between the core's instruction-fetch (IMEM) and load/store (DMEM) requesters. The block sits between the core's IMEM/DMEM interfaces and the memory. It grants one access at a time and holds the memory request until the memory answers. It returns data to the winner with a one-cycle valid pulse and stalls the loser. A streak limiter stops data traffic from starving fetch, and a watchdog aborts accesses the memory never answers.

Parameters:
TIMEOUT, 16, max BUSY cycles waited for mem_ready_i before abort (≥2)
MAX_D_STREAK, 4, max consecutive DMEM grants while IMEM waits (≥1)

Ports:
clk  in  1  clock, all state on rising edge
rst_ni  in  1  asynchronous active-low reset
imem_rd_en_i  in  1  fetch request, level, held until imem_valid_o
imem_addr_i  in  32  fetch address
imem_data_o  out  32  fetch data, valid with imem_valid_o
imem_valid_o  out  1  one-cycle fetch completion pulse
imem_stall_o  out  1  imem_rd_en_i & ~imem_valid_o
dmem_rd_en_i  in  1  load request, level
dmem_wr_en_i  in  1  store request, level
dmem_addr_i  in  32  load/store address
dmem_wdata_i  in  32  store data
dmem_size_i  in  2  byte/half/word
dmem_sign_i  in  1  signed load
dmem_data_o  out  32  load data
dmem_valid_o  out  1  one-cycle load/store completion pulse
dmem_stall_o  out  1  (dmem_rd_en_i|dmem_wr_en_i) & ~dmem_valid_o
err_o  out  1  one-cycle pulse with valid when the access timed out
mem_req_o  out  1  memory request, held until mem_ready_i
mem_we_o  out  1  write
mem_addr_o  out  32  latched address
mem_wdata_o  out  32  latched store data
mem_size_o  out  2  latched size (2'b10 for fetch)
mem_sign_o  out  1  latched sign (0 for fetch)
mem_rdata_i  in  32  memory read data, valid with mem_ready_i
mem_ready_i  in  1  memory completion

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, streak=0, wdog=0.
  - All outputs 0; mem_req_o drops immediately.
  - An in-flight access is discarded, with no valid and no err.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If dmem_rd_en_i|dmem_wr_en_i and !(imem_rd_en_i && streak==MAX_D_STREAK): grant DMEM.
  - Else if imem_rd_en_i: grant IMEM.
  - On grant: latch owner, addr, wdata, size, sign, we; go to BUSY; wdog=0.
  - With no request, stay in IDLE.
- Streak counter:
  - On a DMEM grant while imem_rd_en_i=1: streak+1, saturating at MAX_D_STREAK.
  - On a DMEM grant while imem_rd_en_i=0, or on an IMEM grant: streak=0.
- dmem_rd_en_i and dmem_wr_en_i both high: treated as a store (we=1).
- BUSY:
  - mem_req_o=1; mem_* outputs driven from the latches and stable for the whole state.
  - mem_ready_i=1: capture mem_rdata_i (reads only), go to RESP.
  - Else if wdog==TIMEOUT-1: go to RESP with the error flag set and captured data=0.
  - Else wdog+1.
  - mem_ready_i outside BUSY is ignored.
- RESP (exactly one cycle):
  - Owner's valid_o=1; the data output presents the captured data.
  - err_o=1 if aborted.
  - mem_req_o=0; no grant is made; go to IDLE.
  - This state prevents a duplicate grant while the requester drops its level request.
- Data outputs:
  - imem_data_o updates only on IMEM read completion; dmem_data_o only on DMEM read completion.
  - Both hold their value otherwise.
  - A store completion pulses dmem_valid_o and leaves dmem_data_o unchanged.
- Latency and throughput:
  - A request seen in IDLE at cycle t with zero-wait memory: mem_req_o at t+1, valid at t+2.
  - Sustained throughput: one access per 3 cycles.
- Requester inputs changing during BUSY do not affect the latched access.
- Stall outputs are combinational from the inputs and valid; they are never asserted with no request.

Test Plan:
1. Single fetch: imem_rd_en_i=1 with addr 0x100 at t0, mem_ready_i=1 whenever mem_req_o is high, mem_rdata_i=0x00500093 → mem_req_o=1 with mem_addr_o=0x100, mem_size_o=2'b10 at t1; imem_valid_o=1 and imem_data_o=0x00500093 at t2; imem_stall_o=1 at t0–t1; back in IDLE at t3.
2. Simultaneous requests: imem addr 0x200 and dmem read addr 0x8000 both asserted → DMEM served first, then IMEM; dmem_valid_o at t2, imem_valid_o at t5.
3. Starvation limit, MAX_D_STREAK=2: DMEM and IMEM requests asserted continuously → grant order D, D, I, D, D, I; streak returns to 0 after each I grant.
4. Store with wait states: dmem_wr_en_i, addr 0x10, wdata 0xDEADBEEF, size 2'b10; mem_ready_i arrives after 3 BUSY cycles → mem_we_o=1 and mem_wdata_o stable over all 3 cycles; a single dmem_valid_o pulse; dmem_data_o unchanged.
5. Timeout, TIMEOUT=8: mem_ready_i held 0 → mem_req_o high for exactly 8 cycles; then dmem_valid_o=1 and err_o=1 for one cycle with dmem_data_o=0; the next request is granted normally.
6. Reset mid-access: rst_ni pulled low in the 2nd BUSY cycle → mem_req_o=0 immediately with no valid or err pulse; after release, a pending imem request is granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// One access in flight; data returned with a one-cycle valid pulse.
module mem_port_arbiter #(
    parameter int TIMEOUT      = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  logic        clk,
    input  logic        rst_ni,

    input  logic        imem_rd_en_i,
    input  logic [31:0] imem_addr_i,
    output logic [31:0] imem_data_o,
    output logic        imem_valid_o,
    output logic        imem_stall_o,

    input  logic        dmem_rd_en_i,
    input  logic        dmem_wr_en_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    input  logic [1:0]  dmem_size_i,
    input  logic        dmem_sign_i,
    output logic [31:0] dmem_data_o,
    output logic        dmem_valid_o,
    output logic        dmem_stall_o,

    output logic        err_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic [1:0]  mem_size_o,
    output logic        mem_sign_o,
    input  logic [31:0] mem_rdata_i,
    input  logic        mem_ready_i,

    output logic [1:0]  dbg_state
);

    // Handshake: requesters hold a level request until their one-cycle valid;
    // the memory side holds mem_req_o with stable fields until mem_ready_i.

    localparam int SW = $clog2(MAX_D_STREAK + 1);
    localparam int WW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_STREAK);
    localparam logic [WW-1:0] WDOG_LAST  = WW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic          d_req;
    logic          grant_d, grant_i;
    logic          done, timed_out;

    logic [SW-1:0] streak_q;
    logic [WW-1:0] wdog_q;
    logic          owner_d_q;
    logic          err_q;
    logic [31:0]   addr_q;
    logic [31:0]   wdata_q;
    logic [1:0]    size_q;
    logic          sign_q;
    logic          we_q;
    logic [31:0]   imem_data_q;
    logic [31:0]   dmem_data_q;

    assign d_req     = dmem_rd_en_i | dmem_wr_en_i;
    assign done      = (state_q == BUSY) && (mem_ready_i || (wdog_q == WDOG_LAST));
    assign timed_out = (state_q == BUSY) && !mem_ready_i && (wdog_q == WDOG_LAST);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Data wins unless fetch is waiting and data already had its full streak.
    always_comb begin
        state_d = state_q;
        grant_d = 1'b0;
        grant_i = 1'b0;
        case (state_q)
            IDLE: begin
                if (d_req && !(imem_rd_en_i && (streak_q == STREAK_MAX))) begin
                    grant_d = 1'b1;
                    state_d = BUSY;
                end else if (imem_rd_en_i) begin
                    grant_i = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY:    if (done) state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            streak_q    <= '0;
            wdog_q      <= '0;
            owner_d_q   <= 1'b0;
            err_q       <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            size_q      <= '0;
            sign_q      <= 1'b0;
            we_q        <= 1'b0;
            imem_data_q <= '0;
            dmem_data_q <= '0;
        end else begin
            if (grant_d) begin
                owner_d_q <= 1'b1;
                wdog_q    <= '0;
                err_q     <= 1'b0;
                addr_q    <= dmem_addr_i;
                wdata_q   <= dmem_wdata_i;
                size_q    <= dmem_size_i;
                sign_q    <= dmem_sign_i;
                we_q      <= dmem_wr_en_i;
                if (!imem_rd_en_i)                streak_q <= '0;
                else if (streak_q != STREAK_MAX)  streak_q <= streak_q + SW'(1);
            end else if (grant_i) begin
                owner_d_q <= 1'b0;
                wdog_q    <= '0;
                err_q     <= 1'b0;
                addr_q    <= imem_addr_i;
                wdata_q   <= '0;
                size_q    <= 2'b10;
                sign_q    <= 1'b0;
                we_q      <= 1'b0;
                streak_q  <= '0;
            end

            if ((state_q == BUSY) && !done) wdog_q <= wdog_q + WW'(1);
            if (timed_out)                  err_q  <= 1'b1;

            // An aborted read returns zero; stores never touch load data.
            if (done && !we_q) begin
                if (owner_d_q) dmem_data_q <= mem_ready_i ? mem_rdata_i : '0;
                else           imem_data_q <= mem_ready_i ? mem_rdata_i : '0;
            end
        end
    end

    assign imem_valid_o = (state_q == RESP) && !owner_d_q;
    assign dmem_valid_o = (state_q == RESP) &&  owner_d_q;
    assign err_o        = (state_q == RESP) &&  err_q;
    assign imem_data_o  = imem_data_q;
    assign dmem_data_o  = dmem_data_q;
    assign imem_stall_o = imem_rd_en_i & ~imem_valid_o;
    assign dmem_stall_o = d_req & ~dmem_valid_o;

    assign mem_req_o    = (state_q == BUSY);
    assign mem_we_o     = we_q;
    assign mem_addr_o   = addr_q;
    assign mem_wdata_o  = wdata_q;
    assign mem_size_o   = size_q;
    assign mem_sign_o   = sign_q;

    assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios then randomized traffic,
// checked against a transaction-level arbitration/memory model.
module tb_mem_port_arbiter;

    localparam int TIMEOUT      = 8;
    localparam int MAX_D_STREAK = 2;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        imem_rd_en_i;
    logic [31:0] imem_addr_i;
    logic [31:0] imem_data_o;
    logic        imem_valid_o;
    logic        imem_stall_o;
    logic        dmem_rd_en_i;
    logic        dmem_wr_en_i;
    logic [31:0] dmem_addr_i;
    logic [31:0] dmem_wdata_i;
    logic [1:0]  dmem_size_i;
    logic        dmem_sign_i;
    logic [31:0] dmem_data_o;
    logic        dmem_valid_o;
    logic        dmem_stall_o;
    logic        err_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic [1:0]  mem_size_o;
    logic        mem_sign_o;
    logic [31:0] mem_rdata_i;
    logic        mem_ready_i;
    logic [1:0]  dbg_state;

    mem_port_arbiter #(.TIMEOUT(TIMEOUT), .MAX_D_STREAK(MAX_D_STREAK)) dut (
        .clk(clk), .rst_ni(rst_ni),
        .imem_rd_en_i(imem_rd_en_i), .imem_addr_i(imem_addr_i), .imem_data_o(imem_data_o),
        .imem_valid_o(imem_valid_o), .imem_stall_o(imem_stall_o),
        .dmem_rd_en_i(dmem_rd_en_i), .dmem_wr_en_i(dmem_wr_en_i), .dmem_addr_i(dmem_addr_i),
        .dmem_wdata_i(dmem_wdata_i), .dmem_size_i(dmem_size_i), .dmem_sign_i(dmem_sign_i),
        .dmem_data_o(dmem_data_o), .dmem_valid_o(dmem_valid_o), .dmem_stall_o(dmem_stall_o),
        .err_o(err_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_size_o(mem_size_o), .mem_sign_o(mem_sign_o),
        .mem_rdata_i(mem_rdata_i), .mem_ready_i(mem_ready_i),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_tests;
    int n_fail;

    // requester intent (pins are driven from these)
    logic        i_en;
    logic [31:0] i_addr;
    logic        d_rd, d_wr;
    logic [31:0] d_addr, d_wdata;
    logic [1:0]  d_size;
    logic        d_sign;

    // reference model state
    int          streak_m;
    logic [31:0] imem_data_m;
    logic [31:0] dmem_data_m;

    logic        got_d;
    logic        exp_order [6];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic drive_pins();
        imem_rd_en_i = i_en;
        imem_addr_i  = i_addr;
        dmem_rd_en_i = d_rd;
        dmem_wr_en_i = d_wr;
        dmem_addr_i  = d_addr;
        dmem_wdata_i = d_wdata;
        dmem_size_i  = d_size;
        dmem_sign_i  = d_sign;
    endtask

    task automatic check_cycle(input string tag, input logic [1:0] st, input logic req,
                               input logic iv, input logic dv, input logic er);
        chk({tag, ".state"},   32'(dbg_state),    32'(st));
        chk({tag, ".req"},     32'(mem_req_o),    32'(req));
        chk({tag, ".ivalid"},  32'(imem_valid_o), 32'(iv));
        chk({tag, ".dvalid"},  32'(dmem_valid_o), 32'(dv));
        chk({tag, ".err"},     32'(err_o),        32'(er));
        chk({tag, ".idata"},   imem_data_o,       imem_data_m);
        chk({tag, ".ddata"},   dmem_data_o,       dmem_data_m);
        chk({tag, ".istall"},  32'(imem_stall_o), 32'(imem_rd_en_i & ~iv));
        chk({tag, ".dstall"},  32'(dmem_stall_o), 32'((dmem_rd_en_i | dmem_wr_en_i) & ~dv));
    endtask

    // One arbitration round, entered just after a negedge with requests on the pins.
    // wait_n: memory wait cycles before ready (-1: never). rst_at: BUSY cycle to reset in.
    task automatic run_access(input int wait_n, input int rst_at, input bit fix_rd,
                              input logic [31:0] rd_val, output logic won_d);
        logic        dq, iq, win_d, ok;
        logic [31:0] e_addr, e_wdata, rdata;
        logic [1:0]  e_size;
        logic        e_sign, e_we, ready_now;
        won_d = 1'b0;
        ok    = 1'b0;
        rdata = '0;
        dq = d_rd | d_wr;
        iq = i_en;
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        #1;
        check_cycle("idle", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        if (!dq && !iq) begin
            @(negedge clk);
            return;
        end
        win_d = dq && !(iq && streak_m == MAX_D_STREAK);
        if (win_d) begin
            e_addr = d_addr; e_wdata = d_wdata; e_size = d_size; e_sign = d_sign; e_we = d_wr;
            streak_m = iq ? ((streak_m < MAX_D_STREAK) ? streak_m + 1 : streak_m) : 0;
        end else begin
            e_addr = i_addr; e_wdata = '0; e_size = 2'b10; e_sign = 1'b0; e_we = 1'b0;
            streak_m = 0;
        end
        for (int c = 1; c <= TIMEOUT; c++) begin
            @(negedge clk);
            if (c == rst_at) begin
                rst_ni = 1'b0;
                imem_data_m = '0;
                dmem_data_m = '0;
                streak_m = 0;
                #1;
                check_cycle("rst", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("rst.addr", mem_addr_o, 32'h0);
                chk("rst.we", 32'(mem_we_o), 32'h0);
                @(negedge clk);
                rst_ni = 1'b1;
                drive_pins();
                return;
            end
            ready_now   = (wait_n >= 0) && (c == wait_n + 1);
            rdata       = fix_rd ? rd_val : $urandom;
            mem_ready_i = ready_now;
            mem_rdata_i = rdata;
            // the granted requester's fields may wander; the latched access must not
            if (win_d) begin
                dmem_addr_i  = $urandom;
                dmem_wdata_i = $urandom;
                dmem_size_i  = 2'($urandom_range(0, 3));
                dmem_sign_i  = 1'($urandom_range(0, 1));
            end else begin
                imem_addr_i  = $urandom;
            end
            #1;
            check_cycle("busy", ST_BUSY, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("busy.addr", mem_addr_o, e_addr);
            chk("busy.we", 32'(mem_we_o), 32'(e_we));
            chk("busy.size", 32'(mem_size_o), 32'(e_size));
            chk("busy.sign", 32'(mem_sign_o), 32'(e_sign));
            if (win_d) chk("busy.wdata", mem_wdata_o, e_wdata);
            if (ready_now) begin
                ok = 1'b1;
                break;
            end
        end
        if (!e_we) begin
            if (win_d) dmem_data_m = ok ? rdata : 32'h0;
            else       imem_data_m = ok ? rdata : 32'h0;
        end
        @(negedge clk);
        drive_pins();
        mem_ready_i = 1'($urandom_range(0, 1));
        mem_rdata_i = $urandom;
        #1;
        check_cycle("resp", ST_RESP, 1'b0, !win_d, win_d, !ok);
        won_d = dmem_valid_o;
        @(negedge clk);
        if (win_d) begin
            d_rd = 1'b0;
            d_wr = 1'b0;
        end else begin
            i_en = 1'b0;
        end
        drive_pins();
    endtask

    task automatic set_d(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] sz, input logic sg);
        d_rd = rd; d_wr = wr; d_addr = a; d_wdata = wd; d_size = sz; d_sign = sg;
    endtask

    initial begin
        int wn, ra;
        n_tests = 0;
        n_fail  = 0;
        streak_m = 0;
        imem_data_m = '0;
        dmem_data_m = '0;
        exp_order = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        i_en = 1'b0; i_addr = '0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive_pins();
        mem_ready_i = 1'b0;
        mem_rdata_i = '0;
        rst_ni = 1'b0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        check_cycle("reset", ST_IDLE, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("reset.addr", mem_addr_o, 32'h0);
        rst_ni = 1'b1;
        @(negedge clk);

        // idle with no request: no grant
        run_access(0, 0, 1'b0, 32'h0, got_d);

        // single fetch, zero-wait memory
        i_en = 1'b1; i_addr = 32'h100; drive_pins();
        run_access(0, 0, 1'b1, 32'h0050_0093, got_d);
        chk("fetch.data", imem_data_o, 32'h0050_0093);

        // simultaneous requests: data first, then fetch
        i_en = 1'b1; i_addr = 32'h200;
        set_d(1'b1, 1'b0, 32'h8000, 32'h0, 2'b10, 1'b0);
        drive_pins();
        run_access(0, 0, 1'b0, 32'h0, got_d);
        chk("simul.first_d", 32'(got_d), 32'h1);
        run_access(0, 0, 1'b0, 32'h0, got_d);
        chk("simul.second_i", 32'(got_d), 32'h0);

        // continuous contention: D, D, I, D, D, I
        i_en = 1'b1; i_addr = 32'h300;
        set_d(1'b1, 1'b0, 32'h9000, 32'h0, 2'b10, 1'b1);
        drive_pins();
        for (int k = 0; k < 6; k++) begin
            run_access(0, 0, 1'b0, 32'h0, got_d);
            chk("streak.order", 32'(got_d), 32'(exp_order[k]));
            if (!i_en) begin i_en = 1'b1; i_addr = 32'h300 + 32'(k * 4); end
            if (!d_rd) set_d(1'b1, 1'b0, 32'h9000 + 32'(k * 4), 32'h0, 2'b01, 1'b0);
            drive_pins();
        end
        i_en = 1'b0;
        set_d(1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        drive_pins();

        // store with wait states; load data must not change
        set_d(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0);
        drive_pins();
        run_access(2, 0, 1'b0, 32'h0, got_d);

        // read and write together behave as a store
        set_d(1'b1, 1'b1, 32'h14, 32'h1234_5678, 2'b01, 1'b0);
        drive_pins();
        run_access(1, 0, 1'b0, 32'h0, got_d);

        // ready on the last allowed cycle completes without error
        set_d(1'b1, 1'b0, 32'h20, 32'h0, 2'b00, 1'b1);
        drive_pins();
        run_access(TIMEOUT - 1, 0, 1'b1, 32'hCAFE_F00D, got_d);

        // memory never answers: abort with err and zero data
        set_d(1'b1, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0);
        drive_pins();
        run_access(-1, 0, 1'b0, 32'h0, got_d);
        chk("timeout.ddata", dmem_data_o, 32'h0);
        i_en = 1'b1; i_addr = 32'h44; drive_pins();
        run_access(0, 0, 1'b0, 32'h0, got_d);

        // reset in the second BUSY cycle, then the pending fetch is served
        i_en = 1'b1; i_addr = 32'h500; drive_pins();
        run_access(5, 2, 1'b0, 32'h0, got_d);
        run_access(0, 0, 1'b0, 32'h0, got_d);

        // randomized traffic
        for (int it = 0; it < 250; it++) begin
            if (!i_en && $urandom_range(0, 2) != 0) begin
                i_en = 1'b1;
                i_addr = $urandom & 32'hFFFF_FFFC;
            end
            if (!d_rd && !d_wr && $urandom_range(0, 2) != 0) begin
                case ($urandom_range(0, 2))
                    0:       set_d(1'b1, 1'b0, $urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                    1:       set_d(1'b0, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                    default: set_d(1'b1, 1'b1, $urandom, $urandom, 2'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                endcase
            end
            drive_pins();
            case ($urandom_range(0, 9))
                0:       wn = -1;
                1:       wn = TIMEOUT - 1;
                default: wn = int'($urandom_range(0, 3));
            endcase
            ra = ($urandom_range(0, 19) == 0) ? int'($urandom_range(1, 2)) : 0;
            run_access(wn, ra, 1'b0, 32'h0, got_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
